// File: rtl/ky32_rr_arb_mux.sv
// Round-robin N:1 arbiter/mux with valid/ready on every channel and a registered output stage.
// Optional packet lock (in_last/out_last) is enabled by defining KY32_RR_ARB_MUX_LOCK_EN.
module ky32_rr_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
`ifdef KY32_RR_ARB_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  if (SELW != $clog2(CHANNELS) || CHANNELS < 2 || CHANNELS > 16) begin : g_bad_cfg
    $error("ky32_rr_arb_mux: CHANNELS must be 2..16 and SELW must equal clog2(CHANNELS)");
  end

  // Handshake: a beat moves on channel i at a rising edge when in_valid[i] && in_ready[i];
  // the output beat moves when out_valid && out_ready. in_ready never depends on in_data.
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic [SELW-1:0]  ptr_next;

`ifdef KY32_RR_ARB_MUX_LOCK_EN
  logic             locked;
  logic [SELW-1:0]  lock_ch;
`endif

  assign can_load = !out_valid || out_ready;

  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    // Walk from farthest to nearest so the channel closest to ptr wins.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (in_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = SELW'(idx);
      end
    end
`ifdef KY32_RR_ARB_MUX_LOCK_EN
    if (locked) begin
      grant       = lock_ch;
      grant_valid = in_valid[lock_ch];
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (!rst && can_load && grant_valid) in_ready[grant] = 1'b1;
  end

  assign xfer = !rst && can_load && grant_valid;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SELW'(i) == grant) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign ptr_next = (grant == SELW'(CHANNELS - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef KY32_RR_ARB_MUX_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_data  <= sel_data;
      out_sel   <= grant;
      out_valid <= 1'b1;
`ifdef KY32_RR_ARB_MUX_LOCK_EN
      out_last  <= in_last[grant];
      // Hold the grant on this channel until its last beat; only then rotate.
      if (in_last[grant]) begin
        locked <= 1'b0;
        ptr    <= ptr_next;
      end else begin
        locked  <= 1'b1;
        lock_ch <= grant;
      end
`else
      ptr       <= ptr_next;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ky32_rr_arb_mux.sv
// Directed bench for ky32_rr_arb_mux (4 channels x 32 bits): reset, rotation, skip/wrap,
// backpressure, mid-stream reset and, when KY32_RR_ARB_MUX_LOCK_EN is defined, packet lock.
module tb_ky32_rr_arb_mux;

  localparam int WIDTH = 32;
  localparam int CH    = 4;
  localparam int SELW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [CH-1:0]     in_last;
  logic              out_last;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_sel;
  logic              out_valid;
  logic              out_ready;

  int vectors     = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  ky32_rr_arb_mux #(.WIDTH(WIDTH), .CHANNELS(CH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef KY32_RR_ARB_MUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifndef KY32_RR_ARB_MUX_LOCK_EN
  assign out_last = 1'b0;
`endif

  // Inputs change 1 time unit after a rising edge; checks run 1 unit later, mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [SELW-1:0] s,
                           input logic [WIDTH-1:0] d);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_sel"},   32'(out_sel),   32'(s));
    check({tag, "_data"},  out_data,       d);
  endtask

  initial begin
    // Reset with every channel requesting
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) set_data(i, 32'hA000_0000 | 32'(i));
    tick();
    settle();
    check("rst1_ready", 32'(in_ready), 32'h0);
    check_out("rst1", 1'b0, 2'd0, 32'h0);
    tick();
    settle();
    check("rst2_ready", 32'(in_ready), 32'h0);
    check_out("rst2", 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    settle();
    check("first_grant", 32'(in_ready), 32'h1);

    // Rotation, one beat per cycle
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    while (exp_q.size() > 0) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      tick();
      settle();
      check_out("rr", 1'b1, e[SELW-1:0], 32'hA000_0000 | e);
    end
    check("rr_next_ready", 32'(in_ready), 32'h4);
    tick();
    settle();
    check_out("rr_to3", 1'b1, 2'd2, 32'hA000_0002);

    // Skip and wrap: ptr=3, only ch1 requests
    in_valid = 4'b0010;
    set_data(1, 32'h1111_1111);
    settle();
    check("skip_ready", 32'(in_ready), 32'h2);
    tick();
    settle();
    check_out("skip", 1'b1, 2'd1, 32'h1111_1111);
    set_data(1, 32'hA000_0001);
    in_valid = 4'b1001;
    settle();
    check("wrap_ready", 32'(in_ready), 32'h8);
    tick();
    settle();
    check_out("wrap3", 1'b1, 2'd3, 32'hA000_0003);
    check("wrap0_ready", 32'(in_ready), 32'h1);
    tick();
    settle();
    check_out("wrap0", 1'b1, 2'd0, 32'hA000_0000);

    // Idle cycles drain the output and leave ptr at 1
    in_valid = 4'b0000;
    tick();
    settle();
    check_out("drain", 1'b0, 2'd0, 32'hA000_0000);
    tick();
    in_valid = 4'b1111;
    settle();
    check("idle_ptr", 32'(in_ready), 32'h2);

    // Backpressure
    out_ready = 1'b0;
    tick();
    settle();
    check_out("bp_load", 1'b1, 2'd1, 32'hA000_0001);
    for (int c = 0; c < 5; c++) begin
      check("bp_ready", 32'(in_ready), 32'h0);
      tick();
      settle();
      check_out("bp_hold", 1'b1, 2'd1, 32'hA000_0001);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release_ready", 32'(in_ready), 32'h4);
    tick();
    settle();
    check_out("bp_reload", 1'b1, 2'd2, 32'hA000_0002);

    // Mid-stream reset drops a stalled beat and resets ptr
    set_data(0, 32'hDEAD_BEEF);
    in_valid = 4'b0001;
    settle();
    check("mr_ready", 32'(in_ready), 32'h1);
    tick();
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    settle();
    check_out("mr_load", 1'b1, 2'd0, 32'hDEAD_BEEF);
    tick();
    settle();
    check_out("mr_stall", 1'b1, 2'd0, 32'hDEAD_BEEF);
    rst      = 1'b1;
    in_valid = 4'b1111;
    settle();
    check("mr_rst_ready", 32'(in_ready), 32'h0);
    tick();
    settle();
    check_out("mr_rst", 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    set_data(0, 32'hA000_0000);
    settle();
    check("mr_ptr0", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    tick();
    settle();
    check_out("mr_after", 1'b1, 2'd0, 32'hA000_0000);

`ifdef KY32_RR_ARB_MUX_LOCK_EN
    // Packet lock: ptr=1, ch2 sends a 3-beat packet while ch0 keeps requesting
    in_valid = 4'b0101;
    in_last  = 4'b1011;
    tick();
    settle();
    check_out("lk1", 1'b1, 2'd2, 32'hA000_0002);
    check("lk1_last", 32'(out_last), 32'h0);
    in_valid = 4'b0001;
    settle();
    check("lk_gap_ready", 32'(in_ready), 32'h0);
    tick();
    in_valid = 4'b0101;
    settle();
    check("lk_gap_drain", 32'(out_valid), 32'h0);
    tick();
    settle();
    check_out("lk2", 1'b1, 2'd2, 32'hA000_0002);
    check("lk2_last", 32'(out_last), 32'h0);
    in_last = 4'b1111;
    tick();
    settle();
    check_out("lk3", 1'b1, 2'd2, 32'hA000_0002);
    check("lk3_last", 32'(out_last), 32'h1);
    tick();
    settle();
    check_out("lk_next", 1'b1, 2'd0, 32'hA000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
